// File: rtl/updown_counter_ld.sv
// Up/down counter with prescaled ticks, wrap/saturate, tc/match pulses and a
// three-phase bus load sequencer sharing one bidirectional bus.
module updown_counter_ld #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned PRESCALE_W    = 4,
  parameter logic        DEFAULT_EN    = 1'b1,
  parameter logic        DEFAULT_DRIVE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  dir_i,
  input  logic                  sat_i,
  input  logic                  load_i,
  input  logic                  oe_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [WIDTH-1:0]      cmp_i,
  input  logic [WIDTH-1:0]      bus_in,
  output logic [WIDTH-1:0]      bus_out,
  output logic [WIDTH-1:0]      bus_oe,
  output logic [WIDTH-1:0]      count_o,
  output logic                  tc_o,
  output logic                  match_o
);

  localparam logic [1:0] ST_DRIVE   = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

  logic                  r_en_q, r_dir_q, r_sat_q, r_load_q, r_oe_q, r_load_qq;
  logic [1:0]            r_state, w_state_d;
  logic [PRESCALE_W-1:0] r_pcnt, w_pcnt_d;
  logic [WIDTH-1:0]      r_count, w_count_d, w_step;
  logic                  r_tc, w_tc_d, r_match, w_match_d;
  logic                  w_load_pulse, w_en, w_oe, w_tick, w_capture, w_boundary;

  assign w_load_pulse = r_load_q & ~r_load_qq;
  assign w_en         = DEFAULT_EN | r_en_q;
  assign w_oe         = DEFAULT_DRIVE | r_oe_q;
  assign w_capture    = (r_state == ST_CAPTURE);
  assign w_tick       = (r_pcnt == prescale_i);
  assign w_boundary   = r_dir_q ? ~|r_count : &r_count;
  assign w_step       = r_dir_q ? (r_count - CNT_ONE) : (r_count + CNT_ONE);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_DRIVE:   if (w_load_pulse) w_state_d = ST_RELEASE;
      ST_RELEASE: w_state_d = ST_CAPTURE;
      ST_CAPTURE: w_state_d = ST_DRIVE;
      default:    w_state_d = ST_DRIVE;
    endcase
  end

  // pcnt only resets on tick, so a lowered prescale_i lets it run to rollover.
  always_comb begin
    if (w_capture || w_tick) w_pcnt_d = '0;
    else                     w_pcnt_d = r_pcnt + PCNT_ONE;
  end

  always_comb begin
    w_count_d = r_count;
    w_tc_d    = 1'b0;
    w_match_d = 1'b0;
    if (w_capture) begin
      w_count_d = bus_in;
      w_match_d = (bus_in == cmp_i);
    end else if (w_tick && w_en) begin
      w_tc_d = w_boundary;
      if (!(w_boundary && r_sat_q)) begin
        w_count_d = w_step;
        w_match_d = (w_step == cmp_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_q    <= 1'b0;
      r_dir_q   <= 1'b0;
      r_sat_q   <= 1'b0;
      r_load_q  <= 1'b0;
      r_oe_q    <= 1'b0;
      r_load_qq <= 1'b0;
      r_state   <= ST_DRIVE;
      r_pcnt    <= '0;
      r_count   <= '0;
      r_tc      <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_en_q    <= en_i;
      r_dir_q   <= dir_i;
      r_sat_q   <= sat_i;
      r_load_q  <= load_i;
      r_oe_q    <= oe_i;
      r_load_qq <= r_load_q;
      r_state   <= w_state_d;
      r_pcnt    <= w_pcnt_d;
      r_count   <= w_count_d;
      r_tc      <= w_tc_d;
      r_match   <= w_match_d;
    end
  end

  assign count_o = r_count;
  assign bus_out = r_count;
  assign bus_oe  = {WIDTH{(r_state == ST_DRIVE) & w_oe}};
  assign tc_o    = r_tc;
  assign match_o = r_match;

endmodule

// File: tb/tb_updown_counter_ld.sv
// Directed bench for updown_counter_ld: reset, free run, load, down/saturate,
// prescale, compare and reset during a load.
module tb_updown_counter_ld;

  logic       clk = 1'b0;
  logic       rst, en_i, dir_i, sat_i, load_i, oe_i;
  logic [3:0] prescale_i;
  logic [7:0] cmp_i, bus_in, bus_out, bus_oe, count_o;
  logic       tc_o, match_o;
  int         n_total = 0;
  int         n_bad   = 0;

  updown_counter_ld #(
    .WIDTH(8), .PRESCALE_W(4), .DEFAULT_EN(1'b0), .DEFAULT_DRIVE(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .en_i(en_i), .dir_i(dir_i), .sat_i(sat_i),
    .load_i(load_i), .oe_i(oe_i), .prescale_i(prescale_i), .cmp_i(cmp_i),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .count_o(count_o),
    .tc_o(tc_o), .match_o(match_o)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse load_i for one cycle and stop just after the capture edge (E3).
  task automatic do_load(input logic [7:0] val);
    bus_in = val;
    load_i = 1'b1;
    step(1);
    load_i = 1'b0;
    step(3);
  endtask

  task automatic test_reset;
    rst = 1'b1; en_i = 1'b1; dir_i = 1'b0; sat_i = 1'b0; load_i = 1'b0; oe_i = 1'b1;
    prescale_i = 4'd0; cmp_i = 8'h55; bus_in = 8'h00;
    step(2);
    n_total++;
    if (count_o !== 8'h00 || bus_out !== 8'h00) begin
      n_bad++; $display("FAIL reset_count: got %h/%h want 00", count_o, bus_out);
    end
    n_total++;
    if (bus_oe !== 8'hFF || tc_o !== 1'b0 || match_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_outs: oe=%h tc=%b m=%b want ff 0 0", bus_oe, tc_o, match_o);
    end
  endtask

  task automatic test_free_run;
    logic [7:0] exp;
    rst = 1'b0;
    step(1);
    n_total++;
    if (count_o !== 8'h00) begin
      n_bad++; $display("FAIL free_first: got %h want 00", count_o);
    end
    for (int i = 1; i <= 257; i++) begin
      step(1);
      exp = i[7:0];
      n_total++;
      if (count_o !== exp || tc_o !== (i == 256) || match_o !== (exp == 8'h55)) begin
        n_bad++;
        $display("FAIL free_run[%0d]: cnt=%h tc=%b m=%b want cnt=%h tc=%b m=%b", i, count_o,
                 tc_o, match_o, exp, (i == 256), (exp == 8'h55));
      end
    end
    n_total++;
    if (bus_oe !== 8'hFF) begin
      n_bad++; $display("FAIL free_oe: got %h want ff", bus_oe);
    end
  endtask

  task automatic test_load;
    bus_in = 8'hA5;
    load_i = 1'b1;
    step(1);
    load_i = 1'b0;
    n_total++;
    if (bus_oe !== 8'hFF) begin
      n_bad++; $display("FAIL load_e0_oe: got %h want ff", bus_oe);
    end
    step(1);
    n_total++;
    if (bus_oe !== 8'h00) begin
      n_bad++; $display("FAIL load_e1_oe: got %h want 00", bus_oe);
    end
    load_i = 1'b1;  // second rise, seen while the sequencer is busy
    step(1);
    load_i = 1'b0;
    n_total++;
    if (bus_oe !== 8'h00) begin
      n_bad++; $display("FAIL load_e2_oe: got %h want 00", bus_oe);
    end
    step(1);
    n_total++;
    if (count_o !== 8'hA5 || bus_oe !== 8'hFF) begin
      n_bad++; $display("FAIL load_e3: cnt=%h oe=%h want a5 ff", count_o, bus_oe);
    end
    step(1);
    n_total++;
    if (count_o !== 8'hA6 || bus_oe !== 8'hFF) begin
      n_bad++; $display("FAIL load_e4: cnt=%h oe=%h want a6 ff", count_o, bus_oe);
    end
    step(1);
    n_total++;
    if (count_o !== 8'hA7 || bus_oe !== 8'hFF) begin
      n_bad++; $display("FAIL load_e5: cnt=%h oe=%h want a7 ff", count_o, bus_oe);
    end
  endtask

  task automatic test_down_sat;
    logic [7:0] exp_s[5] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
    logic       tc_s[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_w[5] = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
    logic       tc_w[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dir_i = 1'b1; sat_i = 1'b1;
    do_load(8'h02);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(1);
      n_total++;
      if (count_o !== exp_s[i] || tc_o !== tc_s[i]) begin
        n_bad++; $display("FAIL down_sat[%0d]: cnt=%h tc=%b want %h %b", i, count_o, tc_o,
                          exp_s[i], tc_s[i]);
      end
    end
    sat_i = 1'b0;
    do_load(8'h02);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(1);
      n_total++;
      if (count_o !== exp_w[i] || tc_o !== tc_w[i]) begin
        n_bad++; $display("FAIL down_wrap[%0d]: cnt=%h tc=%b want %h %b", i, count_o, tc_o,
                          exp_w[i], tc_w[i]);
      end
    end
  endtask

  task automatic test_prescale;
    logic [7:0] exp_p[9] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h21, 8'h21, 8'h21, 8'h21, 8'h22};
    dir_i = 1'b0; prescale_i = 4'd3;
    do_load(8'h20);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step(1);
      n_total++;
      if (count_o !== exp_p[i]) begin
        n_bad++; $display("FAIL prescale[%0d]: got %h want %h", i, count_o, exp_p[i]);
      end
    end
    prescale_i = 4'd0;
  endtask

  task automatic test_compare;
    logic [7:0] exp_c[4] = '{8'h0E, 8'h0F, 8'h10, 8'h11};
    logic       m_c[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    cmp_i = 8'h10;
    do_load(8'h0E);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1);
      n_total++;
      if (count_o !== exp_c[i] || match_o !== m_c[i]) begin
        n_bad++; $display("FAIL cmp_count[%0d]: cnt=%h m=%b want %h %b", i, count_o, match_o,
                          exp_c[i], m_c[i]);
      end
    end
    en_i = 1'b0;
    do_load(8'h10);
    n_total++;
    if (count_o !== 8'h10 || match_o !== 1'b1) begin
      n_bad++; $display("FAIL cmp_load: cnt=%h m=%b want 10 1", count_o, match_o);
    end
    for (int i = 0; i < 2; i++) begin
      step(1);
      n_total++;
      if (count_o !== 8'h10 || match_o !== 1'b0) begin
        n_bad++; $display("FAIL cmp_hold[%0d]: cnt=%h m=%b want 10 0", i, count_o, match_o);
      end
    end
    do_load(8'h10);
    n_total++;
    if (count_o !== 8'h10 || match_o !== 1'b1) begin
      n_bad++; $display("FAIL cmp_reload: cnt=%h m=%b want 10 1", count_o, match_o);
    end
  endtask

  task automatic test_reset_mid_load;
    bus_in = 8'h77;
    load_i = 1'b1;
    step(1);
    load_i = 1'b0;
    step(2);
    n_total++;
    if (bus_oe !== 8'h00) begin
      n_bad++; $display("FAIL rml_in_capture: oe=%h want 00", bus_oe);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_total++;
    if (count_o !== 8'h00 || bus_oe !== 8'hFF) begin
      n_bad++; $display("FAIL rml_reset: cnt=%h oe=%h want 00 ff", count_o, bus_oe);
    end
    step(2);
    n_total++;
    if (count_o !== 8'h00 || bus_oe !== 8'hFF || match_o !== 1'b0) begin
      n_bad++; $display("FAIL rml_after: cnt=%h oe=%h m=%b want 00 ff 0", count_o, bus_oe,
                        match_o);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load();
    test_down_sat();
    test_prescale();
    test_compare();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/updown_counter_ld.md
# updown_counter_ld

Parametrised up/down counter with prescaled counting, wrap or saturate mode, compare-match and terminal-count pulses, and a shared bidirectional bus for driving out the count and parallel-loading it. It is the next-generation counter core for the Tiny Tapeout top level. The top level maps dedicated inputs to the control pins and the uio bank to the bus.

## Interface

Parameters:
- WIDTH, 8, counter, bus and compare width (≥2)
- PRESCALE_W, 4, width of the prescale divider setting
- DEFAULT_EN, 1'b1, 1 = count regardless of en_i
- DEFAULT_DRIVE, 1'b1, 1 = drive bus in DRIVE state regardless of oe_i

Ports:
- clk, input, 1, single clock; all state on rising edge
- rst, input, 1, synchronous, active-high reset
- en_i, input, 1, count enable (level, async to clk)
- dir_i, input, 1, 0 = up, 1 = down (level)
- sat_i, input, 1, 0 = wrap, 1 = saturate at limits (level)
- load_i, input, 1, rising edge requests a bus load
- oe_i, input, 1, bus drive enable (level)
- prescale_i, input, PRESCALE_W, tick every prescale_i+1 cycles
- cmp_i, input, WIDTH, compare value
- bus_in, input, WIDTH, bus input path
- bus_out, output, WIDTH, bus output path (= count_o)
- bus_oe, output, WIDTH, bus drive enable, all bits equal
- count_o, output, WIDTH, current count
- tc_o, output, 1, terminal-count pulse
- match_o, output, 1, compare-match pulse

## Operation

- Control sync: en_i, dir_i, sat_i, load_i and oe_i are registered into ctrl_q, and load is also registered again into ctrl_qq. All internal use takes the ctrl_q values.
- load_pulse = ctrl_q.load & ~ctrl_qq.load.
- en = DEFAULT_EN | ctrl_q.en.
- oe = DEFAULT_DRIVE | ctrl_q.oe.
- Load sequencer, states DRIVE(0), RELEASE(1), CAPTURE(2):
  - DRIVE goes to RELEASE on load_pulse.
  - RELEASE goes to CAPTURE unconditionally.
  - CAPTURE goes to DRIVE unconditionally.
  - A load_pulse in RELEASE or CAPTURE is ignored. The request is lost and does not queue.
- bus_oe = {WIDTH{(state==DRIVE) & oe}}. bus_out = count_o at all times.
- Prescaler: pcnt counts 0..prescale_i. tick = (pcnt == prescale_i), and pcnt returns to 0 on tick.
  - prescale_i = 0 gives a tick every cycle.
  - If prescale_i is lowered below pcnt, pcnt wraps to 0 at its next 2^PRESCALE_W rollover. No tick occurs early.
  - pcnt is cleared in CAPTURE.
- Count update priority, highest first:
  1. CAPTURE: count <= bus_in.
  2. tick & en: step by ±1 per ctrl_q.dir.
  3. Otherwise hold.
- Boundaries, where a boundary step is a tick & en with count = 2^WIDTH−1 going up, or count = 0 going down:
  - Wrap mode: count wraps modulo 2^WIDTH.
  - Saturate mode: count holds.
  - tc_o pulses for one cycle, in the cycle after the boundary step, in both modes.
  - tc_o repeats on every further boundary step while saturated.
- match_o pulses for one cycle when an update (a step or CAPTURE) writes a value equal to cmp_i, sampled at that edge.
  - It is aligned with count_o first showing the value.
  - A held count (saturate, disabled or no tick) never re-asserts match_o.
  - A capture that loads the same value as the current count still asserts match_o if that value equals cmp_i.
- Reset (synchronous, overrides everything) clears count, pcnt, state (to DRIVE), ctrl_q, ctrl_qq, tc_o and match_o.
- Reset mid-sequence (RELEASE or CAPTURE) aborts the load; no capture occurs.

## Timing

- Outputs in the cycle after the rst edge:
  - count_o = 0, bus_out = 0
  - bus_oe = {WIDTH{DEFAULT_DRIVE}}
  - tc_o = 0, match_o = 0
- Control latency: a level change on en_i, dir_i, sat_i or oe_i is sampled at edge E0 and takes effect on the E1 update.
- Load timing, with load_i sampled high at E0:
  - E1: state becomes RELEASE and bus_oe goes to 0.
  - E2: state becomes CAPTURE.
  - E3: count takes the bus_in value present during the CAPTURE cycle, and state returns to DRIVE.
  - bus_oe is low for exactly two cycles (E1 to E3).
  - The earliest next accepted load_i rise is the one sampled at E3, which requires load_i low at E2 or earlier.
- tc_o and match_o are registered one-cycle pulses, coincident with the count_o update that caused them.
- The count step occurs at the tick edge: with prescale_i = N, consecutive steps are N+1 cycles apart.

## Test plan

- Reset then free run (WIDTH 8, prescale_i 0, up, wrap): count_o reads 0,1,2,…; after 256 steps count_o = 0 with tc_o high for exactly one cycle; bus_oe = 8'hFF.
- Load: bus_in = 8'hA5, pulse load_i for 1 cycle → bus_oe 8'h00 for 2 cycles, count_o = 8'hA5 at E3, then counting resumes from 8'hA6. A second load_i edge during RELEASE is ignored.
- Down/saturate: load 8'h02, dir 1, sat 1 → count_o 02,01,00,00,…; tc_o pulses on each tick held at 0. In wrap mode the same stimulus gives 00 then FF.
- Prescale: prescale_i = 3 → a step every 4 cycles. A capture mid-period restarts the period: the first step comes 4 cycles after CAPTURE.
- Compare: cmp_i = 8'h10, count up from 8'h0E → match_o high only in the cycle count_o = 8'h10. Loading 8'h10 via the bus also raises match_o; disabling en at 8'h10 gives no further pulses.
- Reset mid-load: assert rst during CAPTURE → count_o = 0, state DRIVE, and bus_in is not captured.
